// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
// Boot-time program loader. It receives a byte stream over a valid/ready
// handshake with this format:
//   LEN_HI, LEN_LO         16-bit word count N
//   N x 4 bytes            each word sent most-significant byte first
//   CSUM                   XOR of all 4N data bytes
// Each assembled word is written into instruction memory through the IM
// write port. The core is held in reset until the whole image has arrived
// and its checksum matches.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   rx_valid      source offers a byte on rx_data
//   rx_data       stream byte
//   rx_ready      loader accepts a byte this cycle (decoded from state)
//   IM_enable     IM port enable, high only in the write cycle
//   IM_write      IM write strobe
//   IM_address    IM word address
//   IMin          IM write data
//   cpu_rst       core reset, released only after a verified load
//   load_done     image loaded and verified (sticky until rst)
//   load_error    length or checksum failure (sticky until rst)
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  IM_enable,
  output logic                  IM_write,
  output logic [ADDR_WIDTH-1:0] IM_address,
  output logic [31:0]           IMin,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Largest legal image: exactly fills the IM.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [31:0]           word;
  logic [7:0]            csum;
  logic [ADDR_WIDTH:0]   idx;
  logic [1:0]            byte_cnt;
  logic                  xfer;
  logic [16:0]           len_rx;
  logic [16:0]           idx_inc;

  // Running checksum accumulation for one stream byte.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
  assign xfer     = rx_valid && rx_ready;
  // Full length as it will be after the LEN_LO handshake, widened so that
  // 2^ADDR_WIDTH itself is representable for the bound check.
  assign len_rx   = {1'b0, len_hi, rx_data};
  // Index value after the increment in S_WRITE, compared against N.
  assign idx_inc  = 17'(idx) + 17'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LEN_HI;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI: begin
        if (xfer) state_next = S_LEN_LO;
        else      state_next = state;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_rx > MAX_WORDS)  state_next = S_ERR;
          else if (len_rx == 17'd0) state_next = S_CSUM;
          else                      state_next = S_DATA;
        end else begin
          state_next = state;
        end
      end
      S_DATA: begin
        if (xfer && (byte_cnt == 2'd3)) state_next = S_WRITE;
        else                            state_next = state;
      end
      S_WRITE: begin
        if (idx_inc == {1'b0, len}) state_next = S_CSUM;
        else                        state_next = S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          if (rx_data == csum) state_next = S_DONE;
          else                 state_next = S_ERR;
        end else begin
          state_next = state;
        end
      end
      S_DONE:  state_next = S_DONE;
      S_ERR:   state_next = S_ERR;
      // An unreachable encoding parks the loader with the core held in reset.
      default: state_next = S_ERR;
    endcase
  end

  // Datapath: length capture, word assembly, checksum, IM port and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi     <= 8'd0;
      len        <= 16'd0;
      word       <= 32'd0;
      csum       <= 8'd0;
      idx        <= '0;
      byte_cnt   <= 2'd0;
      IM_enable  <= 1'b0;
      IM_write   <= 1'b0;
      IM_address <= '0;
      IMin       <= 32'd0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse.
      IM_enable <= 1'b0;
      IM_write  <= 1'b0;
      case (state)
        S_LEN_HI: begin
          if (xfer) len_hi <= rx_data;
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= len_rx[15:0];
            if (len_rx > MAX_WORDS) load_error <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word     <= {word[23:0], rx_data};
            csum     <= csum_update(csum, rx_data);
            byte_cnt <= byte_cnt + 2'd1;
            // The 4th byte's handshake loads the IM port so the strobe is
            // high during the S_WRITE cycle that follows.
            if (byte_cnt == 2'd3) begin
              IM_enable  <= 1'b1;
              IM_write   <= 1'b1;
              IM_address <= idx[ADDR_WIDTH-1:0];
              IMin       <= {word[23:0], rx_data};
            end
          end
        end
        S_WRITE: begin
          idx <= idx + 1'b1;
        end
        S_CSUM: begin
          if (xfer) begin
            if (rx_data == csum) begin
              load_done <= 1'b1;
              cpu_rst   <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader that sits directly upstream of the instruction memory and the processor core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes each word into instruction memory through the IM write port and holds the core in reset until a complete, checksum-verified image is resident. This replaces bench-side `$readmemb` preloading with an in-design load path.

## Interface
- `ADDR_WIDTH`, 10: IM word-address width; capacity is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  source has a byte on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle; the transfer happens when `rx_valid && rx_ready`.
- `IM_enable`  out  1  IM port enable, high only in write cycles.
- `IM_write`  out  1  IM write strobe.
- `IM_address`  out  ADDR_WIDTH  IM word address.
- `IMin`  out  32  IM write data.
- `cpu_rst`  out  1  reset to the core; high until the load completes.
- `load_done`  out  1  image loaded and verified (sticky).
- `load_error`  out  1  length or checksum failure (sticky).

## Operation
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words, 4 bytes each, most-significant byte first; the first byte lands in `IMin[31:24]`.
  - One checksum byte: XOR of all 4N data bytes. The length bytes are excluded.
- States: S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR. Reset state is S_LEN_HI.
- `rx_ready` is decoded from state. It is 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM, and 0 in S_WRITE, S_DONE and S_ERR.
- S_LEN_HI → S_LEN_LO on a handshake.
- S_LEN_LO, on a handshake:
  - N > 2^ADDR_WIDTH → S_ERR.
  - N == 0 → S_CSUM.
  - Otherwise → S_DATA.
- S_DATA: shift the byte into the word register, XOR it into the checksum, and increment a 2-bit byte counter. The handshake on the 4th byte → S_WRITE.
- S_WRITE lasts exactly one cycle:
  - `IM_enable`=`IM_write`=1, `IM_address`=word index, `IMin`=assembled word.
  - The word index then increments.
  - If the index now equals N → S_CSUM, else → S_DATA.
- S_CSUM, on a handshake: byte == running XOR → S_DONE, else → S_ERR.
- S_DONE: `load_done`=1, `cpu_rst`=0. Held until `rst`.
- S_ERR: `load_error`=1, `cpu_rst`=1. Held until `rst`. Further bytes are never accepted.
- The word index and byte counter are ADDR_WIDTH+1 and 2 bits wide. The index never wraps, because N is bounded before S_DATA is entered.
- Reset values:
  - `rx_ready`=1 (S_LEN_HI).
  - `IM_enable`=0, `IM_write`=0, `IM_address`=0, `IMin`=0.
  - `cpu_rst`=1, `load_done`=0, `load_error`=0.
  - Checksum, index and counters = 0.

## Timing
- All outputs are registered or decoded from registered state. No combinational path runs from `rx_valid` or `rx_data` to any output.
- Write latency: the IM write strobe is high in the cycle immediately after the 4th-byte handshake of a word.
- `rx_ready` is 0 during S_WRITE, so each word costs at least 5 cycles.
- A source holding `rx_valid`=1 through S_WRITE must keep `rx_data` stable. That byte is accepted in the first S_DATA or S_CSUM cycle after S_WRITE.
- `rx_valid` gaps of any length are legal. State, partial word and checksum are held while `rx_valid`=0.
- `load_done`, `load_error` and `cpu_rst` change in the cycle after the checksum handshake (or after the LEN_LO handshake for an oversize length).
- Reset mid-load:
  - `rst` asserted at any point immediately forces the reset values, including `cpu_rst`=1.
  - Words already written stay in IM. A new load overwrites them.
  - The partial word is discarded.
- N == 2^ADDR_WIDTH is legal. The last write goes to address 2^ADDR_WIDTH−1.

## Test plan
- Two-word load, stream 00 02 12 34 56 78 DE AD BE EF 2A, `rx_valid` held high:
  - Exactly two IM writes: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF.
  - `load_done`=1 and `cpu_rst`=0 the cycle after the 0x2A handshake.
- Same stream with checksum 0x2B:
  - Both writes still occur.
  - `load_error`=1, `cpu_rst` stays 1, `rx_ready` stays 0 thereafter.
- Zero length, stream 00 00 00: no IM write, `load_done`=1.
- Oversize length, stream 04 01 (1025 words, ADDR_WIDTH=10):
  - S_ERR entered after the second byte.
  - `load_error`=1, no IM write, `rx_ready`=0.
- Backpressure and gaps: the two-word stream with random 0–5 cycle `rx_valid` gaps and `rx_valid` held across S_WRITE. The writes and result must be identical to the first scenario, and no byte may be duplicated or dropped.
- Reset mid-load: assert `rst` after byte 7 of the two-word stream, then resend the full stream.
  - `cpu_rst`=1 immediately on `rst`.
  - Final IM contents are addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF, with `load_done`=1.
